// File: rtl/frame_buffer_ctrl.sv
// Ping-pong frame-buffer controller.
// One single-port 1-bit RAM holds two frame banks. The RAM address MSB
// selects the bank. The capture stage writes into the write bank (wb).
// The processor reads the completed frame from the read bank (rb).
// Camera writes always take the RAM port ahead of processor reads.
// Optional feature: define FRAME_BUFFER_DROP_COUNT_EN to add the
// dropped_frames[7:0] output. It is a saturating count of frames that
// were discarded because the processor still held the previous frame.
module frame_buffer_ctrl #(
    parameter int ADDR_W       = 17,
    parameter int FRAME_PIXELS = 76800
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_wr_en,
    input  logic [ADDR_W-1:0] cap_wr_addr,
    input  logic              cap_wr_data,
    input  logic              cap_frame_done,
    input  logic              proc_rd_req,
    input  logic [ADDR_W-1:0] proc_rd_addr,
    output logic              proc_rd_gnt,
    output logic              proc_rd_valid,
    output logic              proc_rd_data,
    output logic              frame_ready,
    input  logic              frame_release,
    output logic [ADDR_W:0]   ram_addr,
    output logic              ram_we,
    output logic              ram_wdata,
    input  logic              ram_rdata
`ifdef FRAME_BUFFER_DROP_COUNT_EN
    ,
    output logic [7:0]        dropped_frames
`endif
);

    localparam logic [ADDR_W-1:0] FRAME_LIMIT = ADDR_W'(FRAME_PIXELS);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state_reg, state_next;
    logic   wb_reg, wb_next;
    logic   rb_reg, rb_next;
    logic   frame_valid_reg, frame_valid_next;
    logic   rd_pending_reg;
    logic   rd_oor_reg;

    // A frame-done pulse counts only when the frame began at address 0.
    logic accepted_done;
    assign accepted_done = cap_frame_done & frame_valid_reg;

    assign frame_ready = (state_reg == FULL);

    // Bank ownership and frame-validity state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= EMPTY;
            wb_reg          <= 1'b0;
            rb_reg          <= 1'b0;
            frame_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wb_reg          <= wb_next;
            rb_reg          <= rb_next;
            frame_valid_reg <= frame_valid_next;
        end
    end

    // Owner FSM: hand over completed frames, or drop them while the processor is busy.
    always_comb begin
        state_next = state_reg;
        wb_next    = wb_reg;
        rb_next    = rb_reg;
        case (state_reg)
            EMPTY: begin
                if (accepted_done) begin
                    rb_next    = wb_reg;
                    wb_next    = ~wb_reg;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (accepted_done && frame_release) begin
                    // The processor frees its bank just as a new frame completes: swap and stay full.
                    rb_next = wb_reg;
                    wb_next = ~wb_reg;
                end else if (frame_release) begin
                    state_next = EMPTY;
                end
                // If only accepted_done is set, the frame is dropped and the
                // next frame overwrites the same write bank.
            end
            default: state_next = EMPTY;
        endcase
    end

    // A frame becomes valid when address 0 is written, and is closed by frame-done.
    always_comb begin
        frame_valid_next = frame_valid_reg;
        if (cap_frame_done) begin
            frame_valid_next = 1'b0;
        end
        if (cap_wr_en && (cap_wr_addr == '0)) begin
            frame_valid_next = 1'b1;
        end
    end

    // RAM port arbitration: the capture writer takes priority over processor reads.
    always_comb begin
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = 1'b0;
        proc_rd_gnt = 1'b0;
        if (!reset) begin
            if (cap_wr_en) begin
                // An out-of-range write still occupies the port but does not write.
                ram_we    = (cap_wr_addr < FRAME_LIMIT);
                ram_addr  = {wb_reg, cap_wr_addr};
                ram_wdata = cap_wr_data;
            end else if (proc_rd_req && frame_ready) begin
                proc_rd_gnt = 1'b1;
                ram_addr    = {rb_reg, proc_rd_addr};
            end
        end
    end

    // Read-return pipeline that matches the one-cycle RAM read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pending_reg <= 1'b0;
            rd_oor_reg     <= 1'b0;
        end else begin
            rd_pending_reg <= proc_rd_gnt;
            rd_oor_reg     <= proc_rd_gnt && (proc_rd_addr >= FRAME_LIMIT);
        end
    end

    assign proc_rd_valid = rd_pending_reg;
    assign proc_rd_data  = rd_pending_reg & ~rd_oor_reg & ram_rdata;

`ifdef FRAME_BUFFER_DROP_COUNT_EN
    logic [7:0] drop_cnt_reg;

    // Saturating count of frames discarded while the processor held its bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_reg <= 8'd0;
        end else if (frame_ready && accepted_done && !frame_release && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign dropped_frames = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Self-checking bench for frame_buffer_ctrl. It models the external RAM
// and checks processor reads against a scoreboard of expected pixels.
module tb_frame_buffer_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cap_wr_en;
    logic [16:0] cap_wr_addr;
    logic        cap_wr_data;
    logic        cap_frame_done;
    logic        proc_rd_req;
    logic [16:0] proc_rd_addr;
    logic        proc_rd_gnt;
    logic        proc_rd_valid;
    logic        proc_rd_data;
    logic        frame_ready;
    logic        frame_release;
    logic [17:0] ram_addr;
    logic        ram_we;
    logic        ram_wdata;
    logic        ram_rdata;
`ifdef FRAME_BUFFER_DROP_COUNT_EN
    logic [7:0]  dropped_frames;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Bench-side reference state.
    logic exp_wb, exp_rb, exp_ready, exp_fv;
    int   exp_drops;
    logic shadow [0:262143];
    logic exp_q [$];
    logic mem [0:262143];

    frame_buffer_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .cap_wr_en      (cap_wr_en),
        .cap_wr_addr    (cap_wr_addr),
        .cap_wr_data    (cap_wr_data),
        .cap_frame_done (cap_frame_done),
        .proc_rd_req    (proc_rd_req),
        .proc_rd_addr   (proc_rd_addr),
        .proc_rd_gnt    (proc_rd_gnt),
        .proc_rd_valid  (proc_rd_valid),
        .proc_rd_data   (proc_rd_data),
        .frame_ready    (frame_ready),
        .frame_release  (frame_release),
        .ram_addr       (ram_addr),
        .ram_we         (ram_we),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata)
`ifdef FRAME_BUFFER_DROP_COUNT_EN
        ,
        .dropped_frames (dropped_frames)
`endif
    );

    always #5 clk = ~clk;

    // External RAM model: single port with a registered read.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard consumer: each valid read return must match the oldest expected pixel.
    always @(negedge clk) begin
        if (proc_rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected_valid", 32'(1), 32'(0));
            end else begin
                logic e;
                e = exp_q.pop_front();
                check("rd_data", 32'(proc_rd_data), 32'(e));
                $display("read return data=%0d expected=%0d", proc_rd_data, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pix(input int sel, input int i);
        case (sel)
            0: pix = i[0];
            1: pix = ~i[0];
            2: pix = i[1];
            default: pix = i[2];
        endcase
    endfunction

    task automatic model_reset();
        exp_wb = 0; exp_rb = 0; exp_ready = 0; exp_fv = 0; exp_drops = 0;
        exp_q.delete();
    endtask

    task automatic wr(input logic [16:0] a, input logic d);
        logic in_range;
        in_range = (a < 17'd76800);
        cap_wr_en = 1; cap_wr_addr = a; cap_wr_data = d;
        #1;
        check("wr_we", 32'(ram_we), 32'(in_range));
        check("wr_addr", 32'(ram_addr), 32'({exp_wb, a}));
        if (in_range) check("wr_data", 32'(ram_wdata), 32'(d));
        if (in_range) shadow[{exp_wb, a}] = d;
        if (a == 0) exp_fv = 1;
        $display("write addr=%0d data=%0d bank=%0d", a, d, exp_wb);
        step();
        cap_wr_en = 0;
    endtask

    task automatic frame(input int sel);
        for (int i = 0; i < 8; i++) wr(17'(i), pix(sel, i));
    endtask

    task automatic done(input logic rel);
        cap_frame_done = 1; frame_release = rel;
        if (exp_fv) begin
            if (!exp_ready || rel) begin
                exp_rb = exp_wb; exp_wb = ~exp_wb; exp_ready = 1;
            end else begin
                if (exp_drops < 255) exp_drops++;
            end
        end else if (rel && exp_ready) begin
            exp_ready = 0;
        end
        exp_fv = 0;
        step();
        cap_frame_done = 0; frame_release = 0;
        check("frame_ready", 32'(frame_ready), 32'(exp_ready));
`ifdef FRAME_BUFFER_DROP_COUNT_EN
        check("dropped", 32'(dropped_frames), 32'(exp_drops));
`endif
        $display("frame_done rel=%0d ready=%0d", rel, frame_ready);
    endtask

    task automatic release_only();
        frame_release = 1;
        if (exp_ready) exp_ready = 0;
        step();
        frame_release = 0;
        check("release_ready", 32'(frame_ready), 32'(exp_ready));
        $display("release ready=%0d", frame_ready);
    endtask

    // Hold a read request until it is granted; the caller drops proc_rd_req afterwards.
    task automatic rd(input logic [16:0] a);
        logic got;
        got = 0;
        proc_rd_req = 1; proc_rd_addr = a;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (proc_rd_gnt) begin
                got = 1;
                check("rd_addr", 32'(ram_addr), 32'({exp_rb, a}));
                check("rd_we", 32'(ram_we), 32'(0));
                exp_q.push_back((a >= 17'd76800) ? 1'b0 : shadow[{exp_rb, a}]);
                $display("read grant addr=%0d bank=%0d", a, exp_rb);
            end
            step();
        end
        if (!got) check("rd_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        logic [17:0] ra;
        for (int i = 0; i < 262144; i++) begin
            shadow[i] = 1'b0;
            mem[i] = ((i % 131072) >= 76800) ? 1'b1 : 1'b0;
        end
        ram_rdata = 0;
        cap_wr_en = 0; cap_wr_addr = 0; cap_wr_data = 0; cap_frame_done = 0;
        proc_rd_req = 0; proc_rd_addr = 0; frame_release = 0;
        model_reset();

        // While reset is high, the RAM port stays idle whatever the inputs are.
        reset = 1; cap_wr_en = 1; cap_wr_addr = 5; cap_wr_data = 1;
        proc_rd_req = 1; proc_rd_addr = 3;
        step(); #1;
        check("rst_we", 32'(ram_we), 32'(0));
        check("rst_gnt", 32'(proc_rd_gnt), 32'(0));
        check("rst_addr", 32'(ram_addr), 32'(0));
        step();
        reset = 0; cap_wr_en = 0; proc_rd_req = 0;
        check("rst_ready", 32'(frame_ready), 32'(0));
        check("rst_valid", 32'(proc_rd_valid), 32'(0));
        check("rst_rdata", 32'(proc_rd_data), 32'(0));

        // Partial frame with no address-0 start is ignored.
        wr(1, 1); wr(2, 1);
        done(0);

        // Basic handoff into bank 0.
        frame(0);
        done(0);
        rd(3); rd(2); rd(7);
        proc_rd_req = 0;

        // Collision: a capture write to bank 1 blocks a pending read.
        proc_rd_req = 1; proc_rd_addr = 3;
        cap_wr_en = 1; cap_wr_addr = 5; cap_wr_data = 1;
        #1;
        ra = ram_addr;
        check("coll_gnt", 32'(proc_rd_gnt), 32'(0));
        check("coll_we", 32'(ram_we), 32'(1));
        check("coll_bank", 32'(ra[17]), 32'(1));
        shadow[{exp_wb, 17'd5}] = 1;
        $display("collision gnt=%0d we=%0d bank=%0d", proc_rd_gnt, ram_we, ra[17]);
        step();
        cap_wr_en = 0;
        rd(3);
        proc_rd_req = 0;

        // A second frame with no release is dropped; the processor's bank is untouched.
        frame(1);
        done(0);
        rd(3); rd(4);
        proc_rd_req = 0;

        release_only();
        // Requests while empty are never granted.
        proc_rd_req = 1; proc_rd_addr = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("empty_gnt", 32'(proc_rd_gnt), 32'(0));
            step();
        end
        proc_rd_req = 0;

        // A third frame lands in bank 1.
        frame(2);
        done(0);
        rd(2); rd(0); rd(5);
        proc_rd_req = 0;

        // Release and done in the same cycle swap banks and keep frame_ready high.
        frame(3);
        done(1);
        rd(4); rd(3);
        proc_rd_req = 0;

        // Range checks.
        wr(17'd76800, 1);
        rd(17'd80000);
        proc_rd_req = 0;

        // Reset mid-frame: after reset, the frame needs a fresh address-0 start.
        wr(0, 1); wr(1, 0);
        step(); step();
        reset = 1;
        step(); step();
        reset = 0;
        model_reset();
        check("midrst_ready", 32'(frame_ready), 32'(0));
        wr(1, 1);
        done(0);

        step(); step(); step();
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
